// File: rtl/load_store_unit_pkg.sv
// Shared definitions for load_store_unit: access sizes, FSM states, word width.
// Sub-word (byte/half) support is compiled in only when LSU_SUBWORD_EN is defined.
`ifndef WORD
`define WORD 31:0
`endif

package load_store_unit_pkg;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_RESP
  } lsu_state_e;
endpackage

// File: rtl/load_store_unit_align.sv
// lsu_align: combinational load extract/extend and store merge for one word.
// Without LSU_SUBWORD_EN only word accesses exist, so data passes straight through.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]        size,
  input  logic              zero_ext,
  input  logic [1:0]        byte_off,
  input  logic [WORD_W-1:0] rdata,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] load_data,
  output logic [WORD_W-1:0] merge_data
);

`ifdef LSU_SUBWORD_EN
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b     = rdata[{byte_off, 3'b000} +: 8];
    lane_h     = rdata[{byte_off[1], 4'b0000} +: 16];
    load_data  = rdata;
    merge_data = rdata;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{~zero_ext & lane_b[7]}}, lane_b};
        merge_data[{byte_off, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data = {{16{~zero_ext & lane_h[15]}}, lane_h};
        merge_data[{byte_off[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data  = rdata;
        merge_data = wdata;
      end
    endcase
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{size, zero_ext, byte_off};
  assign load_data  = rdata;
  assign merge_data = wdata;
`endif

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: ready/valid load/store front end to a word-wide data memory.
// Define LSU_SUBWORD_EN to enable byte/half accesses (read-modify-write stores).
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned SIZE = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_error,
  output logic [WORD_W-1:0] resp_data,
  output logic              mem_read,
  output logic              mem_write,
  output logic [WORD_W-1:0] mem_address,
  output logic [WORD_W-1:0] mem_write_data,
  input  logic [WORD_W-1:0] mem_read_data
);

  lsu_state_e        state_q, state_d;
  logic              store_q, unsigned_q, err_q;
  logic [1:0]        size_q, off_q;
  logic [WORD_W-1:0] wdata_q, load_q;
  logic [WORD_W-1:0] load_data, merge_data;
  logic              accept, align_ok, req_err;

  assign accept = req_valid && req_ready;

  always_comb begin
    align_ok = 1'b0;
`ifdef LSU_SUBWORD_EN
    case (req_size)
      SZ_BYTE: align_ok = 1'b1;
      SZ_HALF: align_ok = !req_addr[0];
      SZ_WORD: align_ok = (req_addr[1:0] == 2'b00);
      default: align_ok = 1'b0;
    endcase
`else
    align_ok = (req_size == SZ_WORD) && (req_addr[1:0] == 2'b00);
`endif
    req_err = !align_ok || ({2'b00, req_addr[31:2]} >= SIZE);
  end

  lsu_align u_align (
    .size       (size_q),
    .zero_ext   (unsigned_q),
    .byte_off   (off_q),
    .rdata      (mem_read_data),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_err)                  state_d = ST_RESP;
          else if (!req_store)          state_d = ST_RD;
          else if (req_size == SZ_WORD) state_d = ST_WR;
          else                          state_d = ST_RD;
        end
      end
      ST_RD:   state_d = ST_CAP;
      ST_CAP:  state_d = store_q ? ST_WR : ST_RESP;
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      store_q        <= 1'b0;
      unsigned_q     <= 1'b0;
      err_q          <= 1'b0;
      size_q         <= '0;
      off_q          <= '0;
      wdata_q        <= '0;
      load_q         <= '0;
      mem_address    <= '0;
      mem_write_data <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        store_q     <= req_store;
        unsigned_q  <= req_unsigned;
        err_q       <= req_err;
        size_q      <= req_size;
        off_q       <= req_addr[1:0];
        wdata_q     <= req_wdata;
        mem_address <= {2'b00, req_addr[31:2]};
        if (req_store && !req_err && req_size == SZ_WORD)
          mem_write_data <= req_wdata;
      end
      // Read data is only valid during CAP; capture both the extended and merged views.
      if (state_q == ST_CAP) begin
        load_q <= load_data;
        if (store_q)
          mem_write_data <= merge_data;
      end
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign mem_read   = (state_q == ST_RD);
  assign mem_write  = (state_q == ST_WR);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_error = resp_valid && err_q;
  assign resp_data  = (resp_valid && !err_q && !store_q) ? load_q : '0;

endmodule
